// File: rtl/seq_det_multi.sv
// Multi-pattern serial sequence detector with runtime-programmable patterns,
// selectable overlap mode, per-pattern match pulses and a saturating hit counter.
module seq_det_multi #(
    parameter int NUM_PAT = 4,
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter logic [NUM_PAT*PAT_W-1:0] DEFAULT_PATS = 16'b0110_1001_1010_1101,
    localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic               clock_i,
    input  logic               areset_ni,
    input  logic               valid_i,
    input  logic               in_i,
    input  logic               overlap_i,
    input  logic               clear_i,
    input  logic               cfg_we_i,
    input  logic [IDX_W-1:0]   cfg_idx_i,
    input  logic [PAT_W-1:0]   cfg_pat_i,
    input  logic               cfg_en_i,
    output logic [NUM_PAT-1:0] match_o,
    output logic               out_o,
    output logic [CNT_W-1:0]   hit_cnt_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [PAT_W-1:0]   cand;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [NUM_PAT-1:0] match_q, match_d;
    logic [NUM_PAT-1:0] hit;
    logic [NUM_PAT-1:0] en_q;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAT_W-1:0]   pat_q [NUM_PAT];
    logic               armed;

    // Hits are evaluated against the table as it stood before this edge.
    always_comb begin
        cand  = {hist_q[PAT_W-2:0], in_i};
        armed = valid_i && (fill_q >= FILL_W'(PAT_W - 1));
        hit   = '0;
        for (int unsigned k = 0; k < NUM_PAT; k++) begin
            hit[k] = armed && en_q[k] && (cand == pat_q[k]);
        end
    end

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = '0;
        out_d   = 1'b0;
        cnt_d   = cnt_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (valid_i) begin
            hist_d  = cand;
            match_d = hit;
            out_d   = |hit;
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + 1'b1;
            end
            if (|hit) begin
                if (!overlap_i) begin
                    fill_d = '0;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    // Out-of-range indices match no entry, so such writes fall through.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            en_q <= '1;
            for (int unsigned k = 0; k < NUM_PAT; k++) begin
                pat_q[k] <= DEFAULT_PATS[k*PAT_W +: PAT_W];
            end
        end else if (cfg_we_i) begin
            for (int unsigned k = 0; k < NUM_PAT; k++) begin
                if (cfg_idx_i == IDX_W'(k)) begin
                    pat_q[k] <= cfg_pat_i;
                    en_q[k]  <= cfg_en_i;
                end
            end
        end
    end

    assign match_o   = match_q;
    assign out_o     = out_q;
    assign hit_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_det_multi.sv
// Scoreboard bench for seq_det_multi: stimulus pushes model predictions, a
// monitor pops and compares them after every rising edge.
module tb_seq_det_multi;

    localparam int NUM_PAT = 4;
    localparam int PAT_W   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0, din = 1'b0, ov = 1'b1, clr = 1'b0;
    logic       we = 1'b0, cen = 1'b0;
    logic [1:0] cidx = '0;
    logic [3:0] cpat = '0;
    logic [3:0] match_a, match_b;
    logic       out_a, out_b;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    seq_det_multi u_dut (
        .clock_i(clk), .areset_ni(rst_n), .valid_i(valid), .in_i(din),
        .overlap_i(ov), .clear_i(clr), .cfg_we_i(we), .cfg_idx_i(cidx),
        .cfg_pat_i(cpat), .cfg_en_i(cen), .match_o(match_a), .out_o(out_a),
        .hit_cnt_o(cnt_a)
    );

    seq_det_multi #(.CNT_W(3)) u_dut3 (
        .clock_i(clk), .areset_ni(rst_n), .valid_i(valid), .in_i(din),
        .overlap_i(ov), .clear_i(clr), .cfg_we_i(we), .cfg_idx_i(cidx),
        .cfg_pat_i(cpat), .cfg_en_i(cen), .match_o(match_b), .out_o(out_b),
        .hit_cnt_o(cnt_b)
    );

    typedef struct {
        logic [3:0] match;
        logic       out;
        int         cnt8;
        int         cnt3;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: bits received since the last reset/clear/non-overlap hit.
    bit         seen[$];
    logic [3:0] mpat [NUM_PAT];
    bit         men  [NUM_PAT];
    int         mcnt8, mcnt3;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        seen.delete();
        mcnt8 = 0;
        mcnt3 = 0;
        mpat[0] = 4'b1101; mpat[1] = 4'b1010; mpat[2] = 4'b1001; mpat[3] = 4'b0110;
        for (int k = 0; k < NUM_PAT; k++) men[k] = 1'b1;
    endtask

    // One clock of stimulus; the model predicts outputs after the next edge.
    task automatic drive(bit r, bit v, bit b, bit c, bit w, int idx, int p, bit e);
        exp_t x;
        int   win;
        @(negedge clk);
        rst_n = r; valid = v; din = b; clr = c; we = w;
        cidx = 2'(idx); cpat = 4'(p); cen = e;
        x.match = '0;
        x.out   = 1'b0;
        if (!r) begin
            model_reset();
        end else begin
            if (c) begin
                seen.delete();
                mcnt8 = 0;
                mcnt3 = 0;
            end else if (v) begin
                if (seen.size() >= PAT_W - 1) begin
                    win = 0;
                    for (int j = seen.size() - (PAT_W - 1); j < seen.size(); j++)
                        win = win * 2 + int'(seen[j]);
                    win = win * 2 + int'(b);
                    for (int k = 0; k < NUM_PAT; k++)
                        if (men[k] && win == int'(mpat[k])) x.match[k] = 1'b1;
                end
                seen.push_back(b);
                if (seen.size() > PAT_W) void'(seen.pop_front());
                if (x.match != 0) begin
                    x.out = 1'b1;
                    if (!ov) seen.delete();
                    if (mcnt8 < 255) mcnt8++;
                    if (mcnt3 < 7) mcnt3++;
                end
            end
            if (w && idx < NUM_PAT) begin
                mpat[idx] = 4'(p);
                men[idx]  = e;
            end
        end
        x.cnt8 = mcnt8;
        x.cnt3 = mcnt3;
        exp_q.push_back(x);
        if (!r) begin
            #1;
            check("async_reset_out", int'(out_a), 0);
            check("async_reset_cnt", int'(cnt_a) + int'(match_a), 0);
        end
    endtask

    task automatic sample(bit b);
        drive(1'b1, 1'b1, b, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic clear();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        idle();
    endtask

    task automatic send_stream(logic [15:0] s, bit gaps);
        for (int i = 15; i >= 0; i--) begin
            sample(s[i]);
            if (gaps) idle();
        end
        idle();
    endtask

    // Monitor: compares every post-edge output set against the scoreboard.
    initial begin
        exp_t x;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("match_o", int'(match_a), int'(x.match));
                check("out_o", int'(out_a), int'(x.out));
                check("hit_cnt_o", int'(cnt_a), x.cnt8);
                check("match_o_cnt3", int'(match_b), int'(x.match));
                check("hit_cnt_o_cnt3", int'(cnt_b), x.cnt3);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] stream;
        stream = 16'b1010110100110110;
        model_reset();
        do_reset();
        @(posedge clk); #1;
        check("reset_cnt", int'(cnt_a), 0);
        check("reset_match", int'(match_a), 0);

        ov = 1'b1;
        send_stream(stream, 1'b0);
        @(posedge clk); #1;
        check("overlap_total", int'(cnt_a), 8);
        check("cnt3_saturated", int'(cnt_b), 7);

        clear();
        ov = 1'b0;
        send_stream(stream, 1'b0);
        @(posedge clk); #1;
        check("nonoverlap_total", int'(cnt_a), 3);

        clear();
        ov = 1'b1;
        send_stream(stream, 1'b1);
        @(posedge clk); #1;
        check("gapped_total", int'(cnt_a), 8);

        clear();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b1111, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b1001, 1'b0);
        repeat (3) sample(1'b1);
        idle();

        sample(1'b1); sample(1'b1); sample(1'b0);
        do_reset();
        sample(1'b1); idle();
        sample(1'b1); sample(1'b1); sample(1'b0); sample(1'b1); idle();
        @(posedge clk); #1;
        check("default_idx0_after_reset", int'(cnt_a), 1);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4'b0011, 1'b1);
        sample(1'b1); sample(1'b1); sample(1'b0);
        clear();
        sample(1'b1); idle();
        sample(1'b0); sample(1'b0); sample(1'b1); sample(1'b1); idle();

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) ov = ~ov;
            drive($urandom_range(0, 199) != 0,
                  $urandom_range(0, 3) != 0,
                  1'($urandom),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 29) == 0,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 4) != 0);
        end
        idle();
        idle();
        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_multi.md
Name: seq_det_multi

Overview:
- Parametrised overlapping/non-overlapping serial sequence detector. It compares a 1-bit input stream against NUM_PAT programmable patterns, each PAT_W bits wide.
- It is the generalised successor to the fixed 4-pattern, 4-bit detector used in the serial-protocol front end.
- Added over that detector: a valid qualifier, runtime pattern/enable programming, a selectable overlap mode, a per-pattern match vector and a saturating hit counter.

Parameters:
- NUM_PAT, 4, number of patterns (>=1).
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 8, hit counter width.
- DEFAULT_PATS, 16'b0110_1001_1010_1101, reset patterns, NUM_PAT*PAT_W bits. Pattern k = bits [k*PAT_W +: PAT_W], so the defaults are idx0=1101, idx1=1010, idx2=1001, idx3=0110.

Ports:
- clock_i  in  1  clock, rising edge.
- areset_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  in_i carries a sample this cycle.
- in_i  in  1  serial data bit.
- overlap_i  in  1  1 = overlapping detection, 0 = non-overlapping.
- clear_i  in  1  synchronous clear of history, fill count, match_o and counter.
- cfg_we_i  in  1  pattern-table write strobe.
- cfg_idx_i  in  max(1,$clog2(NUM_PAT))  pattern index to write.
- cfg_pat_i  in  PAT_W  pattern value; MSB = first-received bit.
- cfg_en_i  in  1  enable for the indexed pattern.
- match_o  out  NUM_PAT  per-pattern match, registered, one-cycle pulse.
- out_o  out  1  OR of match_o, registered.
- hit_cnt_o  out  CNT_W  saturating count of cycles where out_o was asserted.

Behaviour:
- One clock; reset is asynchronous and active-low (clock_i, areset_ni).
- Reset values:
  - history = 0, fill = 0, match_o = 0, out_o = 0, hit_cnt_o = 0.
  - Patterns = DEFAULT_PATS; all enables = 1.
- History: a PAT_W-bit shift register, newest bit at LSB.
- Fill counter: 0..PAT_W, saturating. It counts valid samples since reset, clear or a non-overlap match.
- Candidate window: cand = {history[PAT_W-2:0], in_i}.
- Hit condition per pattern k: valid_i & (fill >= PAT_W-1) & en[k] & (cand == pat[k]).
- On a valid_i cycle:
  - history <= cand.
  - fill <= min(fill+1, PAT_W).
  - match_o <= hit vector; out_o <= |hit.
- On a valid_i=0 cycle:
  - history and fill hold.
  - match_o and out_o go to 0, so each output is a single-cycle pulse.
- Latency: match_o/out_o assert in the cycle immediately after the clock edge that samples the completing bit.
- Multiple patterns may match on the same sample. All corresponding match_o bits assert; hit_cnt_o increments by 1, not by the popcount.
- Overlap mode: history and fill are unaffected by a match.
- Non-overlap mode (overlap_i=0): on any hit, fill <= 0. The next match therefore needs PAT_W fresh valid bits. History is still updated.
- overlap_i is sampled every cycle; a change applies from the next sample.
- hit_cnt_o: increments by 1 whenever |hit is true on a valid cycle. It saturates at 2^CNT_W-1 and never wraps.
- clear_i (synchronous):
  - history, fill, match_o, out_o and hit_cnt_o <= 0.
  - Has priority over valid_i, so the sample in that cycle is dropped.
  - Patterns and enables are kept.
- Config write (cfg_we_i=1): pat[cfg_idx_i] <= cfg_pat_i and en[cfg_idx_i] <= cfg_en_i at the edge.
  - A sample in the same cycle is compared against the old table.
  - cfg_idx_i >= NUM_PAT: the write is ignored.
- clear_i and cfg_we_i in the same cycle: both take effect.
- areset_ni asserted mid-stream: everything returns to reset values immediately, including patterns (back to DEFAULT_PATS). Partial history is discarded.

Test Plan:
- Reset, overlap=1, defaults, valid every cycle, stream 1010110100110110 MSB-first:
  - out_o pulses after bits 4, 7, 8, 9, 11, 13, 14 and 16.
  - match_o sequence: 0010, 1000, 0001, 0010, 0100, 1000, 0001, 1000.
  - hit_cnt_o = 8 at end.
- Same stream, overlap=0 -> matches only after bits 4 (0010), 8 (0001) and 13 (1000); hit_cnt_o = 3.
- Same stream with valid_i=0 on every other cycle -> identical match sequence and count; outputs are 0 on all gap cycles.
- CNT_W=3, overlap=1, same stream -> hit_cnt_o reaches 7 and holds 7 after the 8th match.
- Write idx0=1111 en=1 and idx2 en=0, then stream 11111 -> match_o = 0001 after bits 4 and 5 only.
  - A sample taken in the write cycle still uses the old pattern.
- Stream 110, pulse areset_ni low, then stream 1 -> no match.
  - After reset, stream 1101 -> match_o = 0001, confirming idx0 is back to its default.
  - clear_i mid-stream behaves the same, except the patterns are retained.
